// File: rtl/sseg_pkg.sv
// sseg_pkg: segment patterns, scan FSM states and digit count shared by the display monitors.
package sseg_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SSEG_0 = 7'h40;
  localparam logic [6:0] SSEG_1 = 7'h79;
  localparam logic [6:0] SSEG_2 = 7'h24;
  localparam logic [6:0] SSEG_3 = 7'h30;
  localparam logic [6:0] SSEG_4 = 7'h19;
  localparam logic [6:0] SSEG_5 = 7'h12;
  localparam logic [6:0] SSEG_6 = 7'h02;
  localparam logic [6:0] SSEG_7 = 7'h78;
  localparam logic [6:0] SSEG_8 = 7'h00;
  localparam logic [6:0] SSEG_9 = 7'h10;
  localparam logic [6:0] SSEG_A = 7'h08;
  localparam logic [6:0] SSEG_B = 7'h03;
  localparam logic [6:0] SSEG_C = 7'h46;
  localparam logic [6:0] SSEG_D = 7'h21;
  localparam logic [6:0] SSEG_E = 7'h06;
  localparam logic [6:0] SSEG_F = 7'h0E;
  localparam logic [6:0] SSEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] SSEG_TABLE = {SSEG_F, SSEG_E, SSEG_D, SSEG_C, SSEG_B, SSEG_A, SSEG_9, SSEG_8,
                                             SSEG_7, SSEG_6, SSEG_5, SSEG_4, SSEG_3, SSEG_2, SSEG_1, SSEG_0};
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;
endpackage

// File: rtl/sseg_pattern_decode.sv
// sseg_pattern_decode: inverse hex table; active-low segments to nibble plus legality flag.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] sseg,
  output logic [3:0] nibble,
  output logic       legal
);
  always_comb begin
    nibble = '0;
    legal = 1'b0;
    for (int k = 0; k < 16; k++)
      if (sseg == SSEG_TABLE[k]) begin
        nibble = 4'(k);
        legal = 1'b1;
      end
  end
endmodule

// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: rebuilds the eight hex digits and DP bits from the multiplexed display lines.
// SSEG_ERRCNT_EN enables the saturating illegal-pattern counter on err_count.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  AN,
  input  logic [6:0]  sseg,
  input  logic        DP,
  output logic [31:0] digits,
  output logic [7:0]  dp_out,
  output logic [7:0]  digit_valid,
  output logic [7:0]  digit_err,
  output logic        upd,
  output logic [2:0]  upd_idx,
  output logic [15:0] err_count
);
  localparam int AW = $clog2(TIMEOUT + 1);
  logic [15:0] s1, s2, s3;
  logic [7:0] cnt, cnt_nxt;
  state_t state, state_nxt;
  logic onehot, changed, cap, legal;
  logic [2:0] idx;
  logic [3:0] nib;
  logic [AW-1:0] age [NUM_DIGITS];
  // s2 = {AN, sseg, DP} after two flops; s3 is the previous s2 for change detection
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {AN, sseg, DP};
      s2 <= s1;
      s3 <= s2;
    end
  assign onehot = $onehot(~s2[15:8]);
  assign changed = s2 != s3;
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!s2[8+i]) idx = 3'(i);
  end
  sseg_pattern_decode u_dec (.sseg(s2[7:1]), .nibble(nib), .legal(legal));
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    cap = 1'b0;
    case (state)
      S_IDLE:
        if (onehot) begin
          state_nxt = S_SETTLE;
          cnt_nxt = 8'd1;
        end
      S_SETTLE:
        if (!onehot) state_nxt = S_IDLE;
        else if (changed) cnt_nxt = 8'd1;
        else if (cnt >= 8'(STABLE_CYCLES - 1)) begin
          cap = 1'b1;
          state_nxt = S_HELD;
        end else cnt_nxt = cnt + 8'd1;
      S_HELD:
        if (!onehot) state_nxt = S_IDLE;
        else if (changed) begin
          state_nxt = S_SETTLE;
          cnt_nxt = 8'd1;
        end
      default: state_nxt = S_IDLE;
    endcase
  end
  // a capture on a digit overrides its timeout in the same cycle
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      digits <= '0;
      dp_out <= '0;
      digit_valid <= '0;
      digit_err <= '0;
      upd <= 1'b0;
      upd_idx <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) age[i] <= '0;
    end else begin
      upd <= cap;
      if (cap) upd_idx <= idx;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (cap && idx == 3'(i)) begin
          if (legal) digits[4*i +: 4] <= nib;
          digit_valid[i] <= legal;
          digit_err[i] <= !legal;
          dp_out[i] <= ~s2[0];
          age[i] <= '0;
        end else if (digit_valid[i]) begin
          age[i] <= age[i] + 1'b1;
          if (age[i] == AW'(TIMEOUT - 1)) digit_valid[i] <= 1'b0;
        end
    end
`ifdef SSEG_ERRCNT_EN
  logic [15:0] err_q;
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) err_q <= '0;
    else if (cap && !legal && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  assign err_count = err_q;
`else
  assign err_count = 16'h0000;
`endif
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb_sseg_scan_decoder: run-length reference model compared every cycle, plus directed literal checks.
module tb_sseg_scan_decoder;
  localparam int STABLE = 4;
  localparam int TMO = 100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] an = 8'hFF;
  logic [6:0] seg = 7'h7F;
  logic dp = 1'b1;
  logic [31:0] digits;
  logic [7:0] dp_out, digit_valid, digit_err;
  logic upd;
  logic [2:0] upd_idx;
  logic [15:0] err_count;
  int passed = 0, total = 0, cyc = 0, upd_seen = 0, last_upd_cyc = 0;
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  sseg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .AN(an), .sseg(seg), .DP(dp),
    .digits(digits), .dp_out(dp_out), .digit_valid(digit_valid), .digit_err(digit_err),
    .upd(upd), .upd_idx(upd_idx), .err_count(err_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    else passed++;
  endtask
  // model: a digit is captured when the sampled bus, seen two clocks late, has been onehot and unchanged for STABLE samples
  logic [15:0] xd1 = '0, xd2 = '0, xnow;
  int rd1 = 1, rd2 = 1, mcyc = 0, m_ec = 0, pat, dig;
  int cap_at [8];
  logic [31:0] m_dig = '0;
  logic [7:0] m_dp = '0, m_val = '0, m_err = '0;
  logic m_upd = 1'b0;
  logic [2:0] m_idx = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xd1 = '0; xd2 = '0; rd1 = 1; rd2 = 1; m_ec = 0;
      m_dig = '0; m_dp = '0; m_val = '0; m_err = '0; m_upd = 1'b0; m_idx = '0;
    end else begin
      mcyc++;
      m_upd = 1'b0;
      if ($countones(~xd2[15:8]) == 1 && rd2 == STABLE) begin
        dig = 0;
        for (int i = 0; i < 8; i++) if (!xd2[8+i]) dig = i;
        pat = -1;
        for (int k = 0; k < 16; k++) if (xd2[7:1] == tbl[k]) pat = k;
        m_upd = 1'b1;
        m_idx = 3'(dig);
        m_dp[dig] = ~xd2[0];
        cap_at[dig] = mcyc;
        if (pat >= 0) begin
          m_dig[4*dig +: 4] = 4'(pat);
          m_val[dig] = 1'b1;
          m_err[dig] = 1'b0;
        end else begin
          m_val[dig] = 1'b0;
          m_err[dig] = 1'b1;
          if (m_ec < 65535) m_ec++;
        end
      end
      for (int i = 0; i < 8; i++)
        if (m_val[i] && !(m_upd && m_idx == 3'(i)) && mcyc - cap_at[i] >= TMO) m_val[i] = 1'b0;
      xnow = {an, seg, dp};
      rd2 = rd1;
      xd2 = xd1;
      rd1 = (xnow == xd1) ? (rd1 < 1000 ? rd1 + 1 : rd1) : 1;
      xd1 = xnow;
    end
  always @(negedge clk) begin
    chk("digits", digits, m_dig);
    chk("dp_out", {24'h0, dp_out}, {24'h0, m_dp});
    chk("digit_valid", {24'h0, digit_valid}, {24'h0, m_val});
    chk("digit_err", {24'h0, digit_err}, {24'h0, m_err});
    chk("upd", {31'h0, upd}, {31'h0, m_upd});
    if (m_upd) chk("upd_idx", {29'h0, upd_idx}, {29'h0, m_idx});
`ifdef SSEG_ERRCNT_EN
    chk("err_count", {16'h0, err_count}, 32'(m_ec));
`else
    chk("err_count", {16'h0, err_count}, 32'h0);
`endif
    if (upd) begin
      upd_seen++;
      last_upd_cyc = cyc;
    end
  end
  task automatic drive(input logic [7:0] a, input logic [6:0] s, input logic d);
    an = a; seg = s; dp = d;
  endtask
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask
  int m, r, fell;
  int vals [8] = '{0, 1, 2, 3, 10, 11, 14, 15};
  initial begin
    hold(3);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", {24'h0, digit_valid}, 32'h0);
    chk("rst_digits", digits, 32'h0);
    upd_seen = 0;
    drive(8'hFE, 7'h40, 1'b1);
    m = cyc;
    hold(10);
    chk("t1_upd_count", upd_seen, 1);
    chk("t1_latency", last_upd_cyc - m, 6);
    chk("t1_nibble", {28'h0, digits[3:0]}, 32'h0);
    chk("t1_valid", {24'h0, digit_valid}, 32'h01);
    chk("t1_dp", {24'h0, dp_out}, 32'h00);
    drive(8'hFF, 7'h7F, 1'b1);
    hold(2);
    upd_seen = 0;
    for (int d = 0; d < 8; d++) begin
      drive(~(8'h01 << d), tbl[vals[d]], d != 3);
      hold(8);
    end
    chk("t2_digits", digits, 32'hFEBA3210);
    chk("t2_valid", {24'h0, digit_valid}, 32'hFF);
    chk("t2_dp", {24'h0, dp_out}, 32'h08);
    chk("t2_upd_count", upd_seen, 8);
    upd_seen = 0;
    drive(8'hFB, 7'h7F, 1'b1);
    hold(8);
    chk("t3_blank_err", {31'h0, digit_err[2]}, 32'h1);
    chk("t3_blank_valid", {31'h0, digit_valid[2]}, 32'h0);
    chk("t3_blank_keep", {28'h0, digits[11:8]}, 32'h2);
`ifdef SSEG_ERRCNT_EN
    chk("t3_err_count", {16'h0, err_count}, 32'h1);
`else
    chk("t3_err_count", {16'h0, err_count}, 32'h0);
`endif
    drive(8'hFB, 7'h24, 1'b1);
    hold(8);
    chk("t3_nibble", {28'h0, digits[11:8]}, 32'h2);
    chk("t3_err_clear", {31'h0, digit_err[2]}, 32'h0);
    chk("t3_valid", {31'h0, digit_valid[2]}, 32'h1);
    chk("t3_upd_count", upd_seen, 2);
    upd_seen = 0;
    for (int t = 0; t < 8; t++) begin
      drive(8'hFD, t[0] ? 7'h24 : 7'h79, 1'b1);
      hold(3);
    end
    drive(8'hF0, 7'h40, 1'b1);
    hold(10);
    drive(8'hFF, 7'h40, 1'b1);
    hold(10);
    chk("t4_no_upd", upd_seen, 0);
    chk("t4_digits", digits, 32'hFEBA3210);
    upd_seen = 0;
    drive(8'hDF, 7'h12, 1'b1);
    m = cyc;
    hold(8);
    chk("t5_upd_count", upd_seen, 1);
    chk("t5_latency", last_upd_cyc - m, 6);
    m = last_upd_cyc;
    drive(8'hFF, 7'h7F, 1'b1);
    fell = 0;
    for (int k = 0; k < 200 && fell == 0; k++) begin
      @(negedge clk);
      if (!digit_valid[5]) fell = 1;
    end
    chk("t5_fell", fell, 1);
    chk("t5_timeout", cyc - m, TMO);
    chk("t5_nibble", {28'h0, digits[23:20]}, 32'h5);
    drive(8'hFE, 7'h79, 1'b1);
    hold(4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_digits", digits, 32'h0);
    chk("t6_valid", {24'h0, digit_valid}, 32'h0);
    chk("t6_dp", {24'h0, dp_out}, 32'h0);
    chk("t6_err", {24'h0, digit_err}, 32'h0);
    chk("t6_upd", {31'h0, upd}, 32'h0);
    chk("t6_err_count", {16'h0, err_count}, 32'h0);
    upd_seen = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    r = cyc;
    hold(10);
    chk("t6_upd_count", upd_seen, 1);
    chk("t6_latency", last_upd_cyc - r, 6);
    chk("t6_nibble", {28'h0, digits[3:0]}, 32'h1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
